// File: rtl/memory_pkg.sv
// Shared constants and request type for the memory_design scratch RAM.
// The optional address check (MEMORY_ADDR_CHECK_EN) reuses addrInRange below.
package memory_pkg;

    localparam int MEM_DEPTH_DEF = 16;
    localparam int MEM_WIDTH_DEF = 8;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_e;

    // Non-power-of-2 depths leave the top of the address space unmapped.
    function automatic logic addrInRange(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/memory_array.sv
// Port logic for the storage array: write/read strobes and the read-data mux.
// It has no handshake logic. The words themselves live in memory_design.mem so that
// hierarchical access through dut.mem reaches them.
module memory_array
    import memory_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEF,
    parameter int WIDTH = MEM_WIDTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0] mem_i [0:DEPTH-1],
    input  logic             en_i,
    input  req_e             req_i,
    input  logic [AW-1:0]    addr_i,
    output logic             we_o,
    output logic             re_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic inRange;

    // Out-of-range writes are dropped. Out-of-range reads still count as reads and return zero.
    always_comb begin
        inRange = addrInRange(32'(addr_i), DEPTH);
        we_o    = en_i && (req_i == REQ_WRITE) && inRange;
        re_o    = en_i && (req_i == REQ_READ);
        rdata_o = '0;
        if (inRange) begin
            rdata_o = mem_i[addr_i];
        end
    end

endmodule

// File: rtl/memory_design.sv
// Single-port synchronous scratch RAM with a valid/ready request interface.
// Define MEMORY_ADDR_CHECK_EN to add err_o, which flags accepted out-of-range accesses.
module memory_design
    import memory_pkg::*;
#(
    parameter int MEMORY_DEPTH  = MEM_DEPTH_DEF,
    parameter int MEMORY_WIDTH  = MEM_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic                     wr_rd_en_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [MEMORY_WIDTH-1:0]  wdata_i,
    output logic                     ready_o,
    output logic [MEMORY_WIDTH-1:0]  rdata_o
`ifdef MEMORY_ADDR_CHECK_EN
    ,
    output logic                     err_o
`endif
);

    logic [MEMORY_WIDTH-1:0] mem [0:MEMORY_DEPTH-1];

    logic                    ready_q;
    logic                    ready_d;
    logic [MEMORY_WIDTH-1:0] rdata_q;
    logic [MEMORY_WIDTH-1:0] rdata_d;
    logic                    transfer;
    logic                    writeEn;
    logic                    readEn;
    logic [MEMORY_WIDTH-1:0] readWord;

    assign transfer = valid_i && ready_q;

    memory_array #(
        .DEPTH (MEMORY_DEPTH),
        .WIDTH (MEMORY_WIDTH),
        .AW    (ADDRESS_WIDTH)
    ) u_array (
        .mem_i   (mem),
        .en_i    (transfer),
        .req_i   (req_e'(wr_rd_en_i)),
        .addr_i  (addr_i),
        .we_o    (writeEn),
        .re_o    (readEn),
        .rdata_o (readWord)
    );

    // There are no wait states, so ready only drops while reset is held.
    always_comb begin
        ready_d = 1'b1;
        rdata_d = rdata_q;
        if (readEn) begin
            rdata_d = readWord;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < MEMORY_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            if (writeEn) begin
                mem[addr_i] <= wdata_i;
            end
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;

`ifdef MEMORY_ADDR_CHECK_EN
    logic err_q;
    logic err_d;

    // One-cycle pulse for any accepted access outside the mapped words.
    always_comb begin
        err_d = transfer && !addrInRange(32'(addr_i), MEMORY_DEPTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_memory_design.sv
// Scoreboard bench for memory_design: the stimulus side pushes expected read data, and a
// monitor pops and compares it one cycle after each accepted read. A 12-word instance covers
// out-of-range addresses.
module tb_memory_design;
   import memory_pkg::*;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int AW    = 4;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             valid_i = 1'b0;
   logic             wr_rd_en_i = 1'b0;
   logic [AW-1:0]    addr_i = '0;
   logic [WIDTH-1:0] wdata_i = '0;
   logic             ready_o;
   logic [WIDTH-1:0] rdata_o;

   logic             v12 = 1'b0;
   logic             wr12 = 1'b0;
   logic [AW-1:0]    addr12 = '0;
   logic [WIDTH-1:0] wd12 = '0;
   logic             ready12;
   logic [WIDTH-1:0] rdata12;
`ifdef MEMORY_ADDR_CHECK_EN
   logic             err_o;
   logic             err12;
`endif

   int total = 0;
   int bad = 0;
   logic [WIDTH-1:0] model [DEPTH];
   logic [WIDTH-1:0] expQ [$];
   logic             readyModel = 1'b0;

   always #5 clk_i = ~clk_i;

   memory_design dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .wr_rd_en_i (wr_rd_en_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .ready_o    (ready_o),
      .rdata_o    (rdata_o)
`ifdef MEMORY_ADDR_CHECK_EN
      ,
      .err_o      (err_o)
`endif
   );

   memory_design #(.MEMORY_DEPTH(12)) dut12 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (v12),
      .wr_rd_en_i (wr12),
      .addr_i     (addr12),
      .wdata_i    (wd12),
      .ready_o    (ready12),
      .rdata_o    (rdata12)
`ifdef MEMORY_ADDR_CHECK_EN
      ,
      .err_o      (err12)
`endif
   );

   // One comparison: it counts toward total and, when the values differ, toward bad.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one request on the main port and update the reference memory.
   task automatic applyStimulus(input logic valid, input logic wr, input int index, input logic [WIDTH-1:0] data);
      int a;
      @(negedge clk_i);
      valid_i    = valid;
      wr_rd_en_i = wr;
      addr_i     = index[AW-1:0];
      wdata_i    = data;
      a = index % DEPTH;
      if (valid) begin
         if (wr) model[a] = data;
         else expQ.push_back(model[a]);
      end
   endtask

   // Hold reset for some cycles, optionally with a write that reset must drop.
   task automatic applyReset(input int cycles, input logic withWrite);
      @(negedge clk_i);
      rst_i      = 1'b1;
      valid_i    = withWrite;
      wr_rd_en_i = 1'b1;
      addr_i     = 4'd8;
      wdata_i    = 8'h33;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk_i);
         #1;
         checkOutput("reset ready_o", ready_o, 0);
         checkOutput("reset rdata_o", rdata_o, 0);
      end
      @(negedge clk_i);
      rst_i   = 1'b0;
      valid_i = 1'b0;
      @(negedge clk_i);
   endtask

   // Drive one request on the 12-word port. It returns in the cycle after the accepting edge.
   task automatic issue12(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk_i);
      v12    = 1'b1;
      wr12   = wr;
      addr12 = a;
      wd12   = d;
      @(negedge clk_i);
      v12 = 1'b0;
   endtask

   // Monitor: checks ready every cycle and pops the expected data one cycle after each accepted read.
   always @(posedge clk_i) begin
      logic wasRead;
      logic [WIDTH-1:0] expected;
      wasRead = valid_i && !wr_rd_en_i && !rst_i && readyModel;
      readyModel = !rst_i;
      #1;
      checkOutput("ready_o", ready_o, readyModel);
      if (wasRead) begin
         if (expQ.size() == 0) begin
            checkOutput("scoreboard underflow", 1, 0);
         end else begin
            expected = expQ.pop_front();
            checkOutput("read rdata_o", rdata_o, expected);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [WIDTH-1:0] seqData [DEPTH];
      int               randAddr [$];
      logic [WIDTH-1:0] bd;

      seqData = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12,
                  8'h01, 8'hE3, 8'h76, 8'h3D, 8'hED, 8'h8C, 8'hF9, 8'h0D};
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      applyReset(2, 1'b0);
      for (int i = 0; i < DEPTH; i++) checkOutput("mem cleared by reset", dut.mem[i], 0);
      applyStimulus(1, 0, 5, 0);

      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, i, seqData[i]);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, i, 0);
      applyStimulus(0, 0, 0, 0);

      applyStimulus(1, 1, 3, 8'hA5);
      applyStimulus(1, 1, 12, 8'h5A);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("backdoor mem[3]", dut.mem[3], 32'b10100101);
      checkOutput("backdoor mem[12]", dut.mem[12], 32'b01011010);

      applyStimulus(1, 1, 0, 8'h11);
      applyStimulus(1, 1, 16, 8'h77);
      applyStimulus(1, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         int a;
         a = $urandom_range(0, DEPTH - 1);
         randAddr.push_back(a);
         applyStimulus(1, 1, a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) applyStimulus(0, 1, 0, 0);
      end
      foreach (randAddr[k]) applyStimulus(1, 0, randAddr[k], 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         bd = dut.mem[i];
         checkOutput("backdoor random image", bd, model[i]);
      end

      applyStimulus(1, 1, 7, 8'hFF);
      applyReset(1, 1'b1);
      applyStimulus(1, 0, 7, 0);
      applyStimulus(1, 0, 8, 0);
      applyStimulus(1, 1, 9, 8'h42);
      applyStimulus(1, 0, 9, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      issue12(1'b1, 4'd5, 8'h3C);
`ifdef MEMORY_ADDR_CHECK_EN
      checkOutput("err after in-range write", err12, 0);
`endif
      issue12(1'b1, 4'd14, 8'h99);
`ifdef MEMORY_ADDR_CHECK_EN
      checkOutput("err after out-of-range write", err12, 1);
`endif
      issue12(1'b0, 4'd5, 8'h00);
      checkOutput("depth12 read in range", rdata12, 8'h3C);
`ifdef MEMORY_ADDR_CHECK_EN
      checkOutput("err clears", err12, 0);
`endif
      issue12(1'b0, 4'd14, 8'h00);
      checkOutput("depth12 read out of range", rdata12, 0);
`ifdef MEMORY_ADDR_CHECK_EN
      checkOutput("err after out-of-range read", err12, 1);
      checkOutput("err on main instance", err_o, 0);
`endif
      for (int i = 0; i < 12; i++) begin
         bd = dut12.mem[i];
         checkOutput("depth12 mem image", bd, (i == 5) ? 8'h3C : 8'h00);
      end

      repeat (3) @(negedge clk_i);
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
